// File: rtl/nco_voice_scheduler.sv
// Multi-voice NCO scheduler: sweeps NUM_VOICES phase accumulators through one shared sine LUT.
// Latency: sample_valid NUM_VOICES+1 cycles after next_sample is accepted; lut_addr/lut_data are same-cycle.
// Backpressure: none; next_sample during a sweep is dropped and flagged by a one-cycle overrun pulse.
// Optional build macro NCO_SCHED_ATTEN_EN adds per-voice 2-bit attenuation (cfg_atten port).
module nco_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int FCW_W      = 24,
  parameter int CODE_W     = 14,
  parameter int LUT_ADDR_W = 8,
  localparam int IDX_W     = $clog2(NUM_VOICES),
  localparam int ACC_W     = CODE_W + IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  next_sample,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_voice,
  input  logic [FCW_W-1:0]      cfg_fcw,
  input  logic                  cfg_en,
  input  logic                  cfg_phase_rst,
`ifdef NCO_SCHED_ATTEN_EN
  input  logic [1:0]            cfg_atten,
`endif
  output logic [LUT_ADDR_W-1:0] lut_addr,
  input  logic [CODE_W-1:0]     lut_data,
  output logic                  busy,
  output logic                  sample_valid,
  output logic [CODE_W-1:0]     sample_code,
  output logic                  overrun
);

  localparam logic [CODE_W-1:0] MID  = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  LAST = IDX_W'(NUM_VOICES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [ACC_W-1:0]        acc;
  logic [FCW_W-1:0]        phase [NUM_VOICES];
  logic [FCW_W-1:0]        fcw   [NUM_VOICES];
  logic [NUM_VOICES-1:0]   en;
`ifdef NCO_SCHED_ATTEN_EN
  logic [1:0]              atten [NUM_VOICES];
  logic signed [CODE_W:0]  diff;
  logic signed [CODE_W:0]  shifted;
`endif
  logic [CODE_W-1:0]       term;
  logic [ACC_W-1:0]        sum;
  logic                    cfg_hit;

  // idx rests at 0 while idle, so the shared LUT then shows voice 0's phase.
  assign lut_addr = phase[idx][FCW_W-1 -: LUT_ADDR_W];

  // Writes addressed past the last voice are dropped.
  assign cfg_hit = ({1'b0, cfg_voice} < (IDX_W+1)'(NUM_VOICES));

  // Contribution of the voice under service; a muted voice sits at mid-scale.
  always_comb begin
    term = MID;
`ifdef NCO_SCHED_ATTEN_EN
    diff    = $signed({1'b0, lut_data}) - $signed({1'b0, MID});
    shifted = diff >>> atten[idx];
    if (en[idx]) term = CODE_W'($signed({1'b0, MID}) + shifted);
`else
    if (en[idx]) term = lut_data;
`endif
    sum = acc + ACC_W'(term);
  end

  // Sweep FSM, per-voice phase stepping and the configuration register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      sample_code  <= MID;
      en           <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        fcw[v]   <= '0;
`ifdef NCO_SCHED_ATTEN_EN
        atten[v] <= '0;
`endif
      end
    end else begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      case (state)
        IDLE: begin
          if (next_sample) begin
            state <= RUN;
            busy  <= 1'b1;
            idx   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          if (next_sample) overrun <= 1'b1;
          if (en[idx]) phase[idx] <= phase[idx] + fcw[idx];
          acc <= sum;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            sample_code  <= sum[ACC_W-1:IDX_W];
            sample_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed after the sweep so a phase clear overrides the same-cycle phase step.
      if (cfg_we && cfg_hit) begin
        fcw[cfg_voice] <= cfg_fcw;
        en[cfg_voice]  <= cfg_en;
`ifdef NCO_SCHED_ATTEN_EN
        atten[cfg_voice] <= cfg_atten;
`endif
        if (cfg_phase_rst) phase[cfg_voice] <= '0;
      end
    end
  end

endmodule
